// File: rtl/sdr_dsp_pkg.sv
// Shared DSP constants and helpers for the receive-side sample-rate path.
package sdr_dsp_pkg;

   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned DECIM_LOG2_MIN = 1;
   localparam int unsigned DECIM_LOG2_MAX = 6;

   // Per-rail accumulator command, decided once in the top and shared by both rails.
   typedef enum logic [2:0] {
      WIN_HOLD  = 3'd0,
      WIN_ADD   = 3'd1,
      WIN_DUMP  = 3'd2,
      WIN_CLEAR = 3'd3,
      WIN_LOAD  = 3'd4
   } win_op_e;

   // Headroom of DECIM_LOG2 bits makes a full window sum overflow-free.
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned decim_log2);
      return data_w + decim_log2;
   endfunction

   function automatic bit decim_log2_legal(input int unsigned decim_log2);
      return (decim_log2 >= DECIM_LOG2_MIN) && (decim_log2 <= DECIM_LOG2_MAX);
   endfunction

endpackage

// File: rtl/iq_boxcar_acc.sv
// One rail of the integrate-and-dump decimator: accumulator plus dump shift.
// Rounding on dump is enabled by defining IQ_DECIM_ROUND_EN.
module iq_boxcar_acc
   import sdr_dsp_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DECIM_LOG2 = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  win_op_e                  op_i,
   input  logic signed [DATA_W-1:0] x_i,
   output logic signed [DATA_W-1:0] y_o
);

   localparam int unsigned ACC_W = acc_width(DATA_W, DECIM_LOG2);

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] y_q, y_d;
   logic signed [ACC_W-1:0]  x_ext;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  pre;

`ifdef IQ_DECIM_ROUND_EN
   // Half an LSB of the output; the headroom bits absorb it without overflow.
   localparam int unsigned HALF = 1 << (DECIM_LOG2 - 1);
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(HALF);
`endif

   always_comb begin
      x_ext = {{DECIM_LOG2{x_i[DATA_W-1]}}, x_i};
      sum   = acc_q + x_ext;
`ifdef IQ_DECIM_ROUND_EN
      pre   = sum + RND;
`else
      pre   = sum;
`endif
      acc_d = acc_q;
      y_d   = y_q;
      case (op_i)
         WIN_ADD:   acc_d = sum;
         WIN_DUMP: begin
            acc_d = '0;
            y_d   = DATA_W'(pre >>> DECIM_LOG2);
         end
         WIN_CLEAR: acc_d = '0;
         WIN_LOAD:  acc_d = x_ext;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         y_q   <= '0;
      end else begin
         acc_q <= acc_d;
         y_q   <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/iq_decimator.sv
// I/Q boxcar decimator by R = 2^DECIM_LOG2 with sticky I/Q valid-misalignment flag.
// Define IQ_DECIM_ROUND_EN for round-half-up on dump instead of floor.
module iq_decimator
   import sdr_dsp_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DECIM_LOG2 = 1
) (
   input  logic                     clk_32M768,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] I_tdata,
   input  logic                     I_tvalid,
   input  logic signed [DATA_W-1:0] Q_tdata,
   input  logic                     Q_tvalid,
   input  logic                     phase_sync,
   output logic signed [DATA_W-1:0] I_decim_tdata,
   output logic signed [DATA_W-1:0] Q_decim_tdata,
   output logic                     decim_tvalid,
   output logic                     iq_misalign
);

   if (!decim_log2_legal(DECIM_LOG2)) begin : g_bad_decim_log2
      $error("iq_decimator: DECIM_LOG2 out of legal range");
   end

   localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
   logic                  vld_q, vld_d;
   logic                  mis_q, mis_d;
   logic                  acc_c;
   win_op_e               win_op;

   assign acc_c = I_tvalid & Q_tvalid;

   // Window control: phase_sync outranks a dump and restarts with the current sample.
   always_comb begin
      cnt_d  = cnt_q;
      vld_d  = 1'b0;
      win_op = WIN_HOLD;
      mis_d  = (phase_sync ? 1'b0 : mis_q) | (I_tvalid ^ Q_tvalid);
      if (phase_sync) begin
         if (acc_c) begin
            win_op = WIN_LOAD;
            cnt_d  = DECIM_LOG2'(1);
         end else begin
            win_op = WIN_CLEAR;
            cnt_d  = '0;
         end
      end else if (acc_c) begin
         if (cnt_q == CNT_LAST) begin
            win_op = WIN_DUMP;
            cnt_d  = '0;
            vld_d  = 1'b1;
         end else begin
            win_op = WIN_ADD;
            cnt_d  = cnt_q + DECIM_LOG2'(1);
         end
      end
   end

   always_ff @(posedge clk_32M768 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         mis_q <= mis_d;
      end
   end

   iq_boxcar_acc #(.DATA_W(DATA_W), .DECIM_LOG2(DECIM_LOG2)) u_acc_i (
      .clk   (clk_32M768),
      .rst_n (rst_n),
      .op_i  (win_op),
      .x_i   (I_tdata),
      .y_o   (I_decim_tdata)
   );

   iq_boxcar_acc #(.DATA_W(DATA_W), .DECIM_LOG2(DECIM_LOG2)) u_acc_q (
      .clk   (clk_32M768),
      .rst_n (rst_n),
      .op_i  (win_op),
      .x_i   (Q_tdata),
      .y_o   (Q_decim_tdata)
   );

   assign decim_tvalid = vld_q;
   assign iq_misalign  = mis_q;

endmodule
